// File: rtl/mc_chroma_fetch.sv
// Chroma reference fetch: converts block position + 1/8-pel MV into a strip-by-strip
// window read sequence and forwards 3 U / 3 V pixels per row to the interpolator.
module mc_chroma_fetch #(
   parameter int BIT_DEPTH = 8,
   parameter int WIN_W     = 48,
   parameter int WIN_H     = 48,
   parameter int POS_W     = 6,
   parameter int MV_W      = 10
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   start_i,
   input  logic [POS_W-1:0]       blk_x_i,
   input  logic [POS_W-1:0]       blk_y_i,
   input  logic [MV_W-1:0]        mv_x_i,
   input  logic [MV_W-1:0]        mv_y_i,
   input  logic [1:0]             blk_w_i,
   input  logic [1:0]             blk_h_i,
   output logic                   busy_o,
   output logic                   rd_en_o,
   output logic [POS_W-1:0]       rd_x_o,
   output logic [POS_W-1:0]       rd_y_o,
   input  logic [3*BIT_DEPTH-1:0] rd_u_i,
   input  logic [3*BIT_DEPTH-1:0] rd_v_i,
   output logic [5:0]             frac0_o,
   output logic [5:0]             frac1_o,
   output logic                   end_oneblk_rd_o,
   output logic                   refuv_valid_o,
   output logic [BIT_DEPTH-1:0]   refuv0_p0_o,
   output logic [BIT_DEPTH-1:0]   refuv0_p1_o,
   output logic [BIT_DEPTH-1:0]   refuv0_p2_o,
   output logic [BIT_DEPTH-1:0]   refuv1_p0_o,
   output logic [BIT_DEPTH-1:0]   refuv1_p1_o,
   output logic [BIT_DEPTH-1:0]   refuv1_p2_o
);

   // Wide enough for position + MV offset + strip/row step without wrapping.
   localparam int CW = POS_W + 4;
   localparam logic signed [CW-1:0] XMAX = CW'(WIN_W - 3);
   localparam logic signed [CW-1:0] YMAX = CW'(WIN_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

   function automatic logic [POS_W-1:0] clamp_x(input logic signed [CW-1:0] v);
      if (v[CW-1])      return '0;
      else if (v > XMAX) return XMAX[POS_W-1:0];
      else              return v[POS_W-1:0];
   endfunction

   function automatic logic [POS_W-1:0] clamp_y(input logic signed [CW-1:0] v);
      if (v[CW-1])      return '0;
      else if (v > YMAX) return YMAX[POS_W-1:0];
      else              return v[POS_W-1:0];
   endfunction

   // Last row index equals H, since each strip is H+1 rows deep.
   function automatic logic [3:0] rows_of(input logic [1:0] code);
      case (code)
         2'd0:    return 4'd2;
         2'd1:    return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

   function automatic logic [1:0] last_strip_of(input logic [1:0] code);
      case (code)
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   state_t                 r_state;
   logic                   r_drain;
   logic signed [CW-1:0]   r_ix;
   logic signed [CW-1:0]   r_iy;
   logic [1:0]             r_s;
   logic [1:0]             r_last_strip;
   logic [3:0]             r_r;
   logic [3:0]             r_h;
   logic                   r_rd_last;
   logic                   r_busy;
   logic                   r_rd_en;
   logic [POS_W-1:0]       r_rd_x;
   logic [POS_W-1:0]       r_rd_y;
   logic [5:0]             r_frac;
   logic                   r_vld_p0;
   logic                   r_last_p0;
   logic                   r_vld_p1;
   logic                   r_last_p1;
   logic [3*BIT_DEPTH-1:0] r_u_p1;
   logic [3*BIT_DEPTH-1:0] r_v_p1;

   logic signed [MV_W-1:0] w_mvx;
   logic signed [MV_W-1:0] w_mvy;
   logic signed [CW-1:0]   w_ix;
   logic signed [CW-1:0]   w_iy;
   logic                   w_wrap;
   logic [1:0]             w_s_nx;
   logic [3:0]             w_r_nx;
   logic signed [CW-1:0]   w_sx;
   logic signed [CW-1:0]   w_ry;

   assign w_mvx  = $signed(mv_x_i) >>> 3;
   assign w_mvy  = $signed(mv_y_i) >>> 3;
   assign w_ix   = $signed({{(CW-POS_W){1'b0}}, blk_x_i}) + CW'(w_mvx);
   assign w_iy   = $signed({{(CW-POS_W){1'b0}}, blk_y_i}) + CW'(w_mvy);
   assign w_wrap = (r_r == r_h);
   assign w_s_nx = w_wrap ? r_s + 2'd1 : r_s;
   assign w_r_nx = w_wrap ? 4'd0 : r_r + 4'd1;
   assign w_sx   = r_ix + $signed({{(CW-3){1'b0}}, w_s_nx, 1'b0});
   assign w_ry   = r_iy + $signed({{(CW-4){1'b0}}, w_r_nx});

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= S_IDLE;
         r_drain      <= 1'b0;
         r_ix         <= '0;
         r_iy         <= '0;
         r_s          <= '0;
         r_last_strip <= '0;
         r_r          <= '0;
         r_h          <= '0;
         r_rd_last    <= 1'b0;
         r_busy       <= 1'b0;
         r_rd_en      <= 1'b0;
         r_rd_x       <= '0;
         r_rd_y       <= '0;
         r_frac       <= '0;
         r_vld_p0     <= 1'b0;
         r_last_p0    <= 1'b0;
         r_vld_p1     <= 1'b0;
         r_last_p1    <= 1'b0;
         r_u_p1       <= '0;
         r_v_p1       <= '0;
      end else begin
         // p0: memory answers the read issued last cycle
         r_vld_p0  <= r_rd_en;
         r_last_p0 <= r_rd_en & r_rd_last;
         // p1: row registered onto the interpolator-facing outputs
         r_vld_p1  <= r_vld_p0;
         r_last_p1 <= r_last_p0;
         if (r_vld_p0) begin
            r_u_p1 <= rd_u_i;
            r_v_p1 <= rd_v_i;
         end

         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_state      <= S_FETCH;
                  r_busy       <= 1'b1;
                  r_ix         <= w_ix;
                  r_iy         <= w_iy;
                  r_s          <= '0;
                  r_r          <= '0;
                  r_last_strip <= last_strip_of(blk_w_i);
                  r_h          <= rows_of(blk_h_i);
                  r_frac       <= {mv_y_i[2:0], mv_x_i[2:0]};
                  r_rd_en      <= 1'b1;
                  r_rd_x       <= clamp_x(w_ix);
                  r_rd_y       <= clamp_y(w_iy);
                  r_rd_last    <= 1'b0;
               end
            end
            S_FETCH: begin
               if (r_rd_last) begin
                  r_state   <= S_DRAIN;
                  r_drain   <= 1'b0;
                  r_rd_en   <= 1'b0;
                  r_rd_last <= 1'b0;
               end else begin
                  r_s       <= w_s_nx;
                  r_r       <= w_r_nx;
                  r_rd_x    <= clamp_x(w_sx);
                  r_rd_y    <= clamp_y(w_ry);
                  r_rd_last <= (w_s_nx == r_last_strip) && (w_r_nx == r_h);
               end
            end
            S_DRAIN: begin
               if (r_drain) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_drain <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_rd_en <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o          = r_busy;
   assign rd_en_o         = r_rd_en;
   assign rd_x_o          = r_rd_x;
   assign rd_y_o          = r_rd_y;
   assign frac0_o         = r_frac;
   assign frac1_o         = r_frac;
   assign refuv_valid_o   = r_vld_p1;
   assign end_oneblk_rd_o = r_last_p1;
   assign refuv0_p0_o     = r_u_p1[BIT_DEPTH-1:0];
   assign refuv0_p1_o     = r_u_p1[2*BIT_DEPTH-1:BIT_DEPTH];
   assign refuv0_p2_o     = r_u_p1[3*BIT_DEPTH-1:2*BIT_DEPTH];
   assign refuv1_p0_o     = r_v_p1[BIT_DEPTH-1:0];
   assign refuv1_p1_o     = r_v_p1[2*BIT_DEPTH-1:BIT_DEPTH];
   assign refuv1_p2_o     = r_v_p1[3*BIT_DEPTH-1:2*BIT_DEPTH];

endmodule

// File: tb/tb_mc_chroma_fetch.sv
// Directed bench for mc_chroma_fetch: vector table of blocks plus hand sequences
// for ignored/back-to-back starts and reset in the middle of a block.
module tb_mc_chroma_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [5:0]  bx, by;
   logic [9:0]  mx, my;
   logic [1:0]  wc, hc;
   logic        busy, rd_en, rd_end, rvalid;
   logic [5:0]  rdx, rdy, frac0, frac1;
   logic [23:0] ru, rv;
   logic [7:0]  u0, u1, u2, v0, v1, v2;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int bx, by, mx, my, wc, hc, ix, iy, h, n, frac;
   } vec_t;
   vec_t vt[6];

   int gx[64];
   int gy[64];

   always #5 clk = ~clk;

   mc_chroma_fetch dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
      .blk_x_i(bx), .blk_y_i(by), .mv_x_i(mx), .mv_y_i(my),
      .blk_w_i(wc), .blk_h_i(hc),
      .busy_o(busy), .rd_en_o(rd_en), .rd_x_o(rdx), .rd_y_o(rdy),
      .rd_u_i(ru), .rd_v_i(rv),
      .frac0_o(frac0), .frac1_o(frac1),
      .end_oneblk_rd_o(rd_end), .refuv_valid_o(rvalid),
      .refuv0_p0_o(u0), .refuv0_p1_o(u1), .refuv0_p2_o(u2),
      .refuv1_p0_o(v0), .refuv1_p1_o(v1), .refuv1_p2_o(v2)
   );

   function automatic logic [7:0] pu(input int x, input int y);
      return 8'(x * 7 + y * 13 + 1);
   endfunction

   function automatic logic [7:0] pv(input int x, input int y);
      return 8'(x * 5 + y * 11 + 77);
   endfunction

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   // Window memory: one-cycle read latency.
   initial begin
      ru = '0;
      rv = '0;
   end
   always @(posedge clk) begin
      if (rd_en) begin
         ru <= {pu(int'(rdx) + 2, int'(rdy)), pu(int'(rdx) + 1, int'(rdy)), pu(int'(rdx), int'(rdy))};
         rv <= {pv(int'(rdx) + 2, int'(rdy)), pv(int'(rdx) + 1, int'(rdy)), pv(int'(rdx), int'(rdy))};
      end
   end

   task automatic check(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic apply(input int i);
      bx = 6'(vt[i].bx);
      by = 6'(vt[i].by);
      mx = 10'(vt[i].mx);
      my = 10'(vt[i].my);
      wc = 2'(vt[i].wc);
      hc = 2'(vt[i].hc);
   endtask

   task automatic run_block(input int i);
      int nrd, nvl, nend, endcyc, busy_low, firstrd, firstvl, s, r, x, y;
      nrd = 0; nvl = 0; nend = 0; endcyc = -1; busy_low = -1; firstrd = -1; firstvl = -1;
      @(negedge clk);
      apply(i);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("v%0d frac0", i), frac0, vt[i].frac);
      check($sformatf("v%0d frac1", i), frac1, vt[i].frac);
      for (int c = 1; c < 200; c++) begin
         if (c > 1) @(negedge clk);
         if (rd_en) begin
            if (firstrd < 0) firstrd = c;
            s = nrd / (vt[i].h + 1);
            r = nrd % (vt[i].h + 1);
            if (nrd < 64) begin
               gx[nrd] = int'(rdx);
               gy[nrd] = int'(rdy);
            end
            check($sformatf("v%0d rd_x[%0d]", i, nrd), rdx, clampi(vt[i].ix + 2 * s, 45));
            check($sformatf("v%0d rd_y[%0d]", i, nrd), rdy, clampi(vt[i].iy + r, 47));
            nrd++;
         end
         if (rvalid) begin
            if (firstvl < 0) firstvl = c;
            s = nvl / (vt[i].h + 1);
            r = nvl % (vt[i].h + 1);
            x = clampi(vt[i].ix + 2 * s, 45);
            y = clampi(vt[i].iy + r, 47);
            check($sformatf("v%0d U row %0d", i, nvl), {u2, u1, u0}, {pu(x + 2, y), pu(x + 1, y), pu(x, y)});
            check($sformatf("v%0d V row %0d", i, nvl), {v2, v1, v0}, {pv(x + 2, y), pv(x + 1, y), pv(x, y)});
            nvl++;
         end
         if (rd_end) begin
            nend++;
            endcyc = c;
         end
         if (!busy) begin
            busy_low = c;
            break;
         end
      end
      check($sformatf("v%0d reads", i), nrd, vt[i].n);
      check($sformatf("v%0d valids", i), nvl, vt[i].n);
      check($sformatf("v%0d end pulses", i), nend, 1);
      check($sformatf("v%0d end cycle", i), endcyc, vt[i].n + 2);
      check($sformatf("v%0d first rd_en cycle", i), firstrd, 1);
      check($sformatf("v%0d first valid cycle", i), firstvl, 3);
      check($sformatf("v%0d busy low cycle", i), busy_low, vt[i].n + 3);
   endtask

   initial begin
      int cnt;
      //          bx  by   mx   my wc hc  ix  iy  h   n frac
      vt[0] = '{  8,  8,  13,  -6, 1, 1,  9,  7, 4, 10, 21};
      vt[1] = '{  3,  4,   0,   0, 0, 0,  3,  4, 2,  3,  0};
      vt[2] = '{ 10, 20,  -9,  17, 2, 2,  8, 22, 8, 36, 15};
      vt[3] = '{  0,  0, -20, -20, 2, 2, -3, -3, 8, 36, 36};
      vt[4] = '{ 46, 46,   0,   0, 1, 1, 46, 46, 4, 10,  0};
      vt[5] = '{  5,  5,   7,   7, 3, 3,  5,  5, 8, 36, 63};

      rst_n = 1'b0;
      start = 1'b0;
      apply(1);
      repeat (3) @(negedge clk);
      check("reset busy/rd_en/valid/end", {busy, rd_en, rvalid, rd_end}, 0);
      check("reset rd_x/rd_y/frac", {rdx, rdy, frac0, frac1}, 0);
      check("reset refuv", {u0, u1, u2, v0, v1, v2}, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_block(i);
         if (i == 3) begin
            check("clamp rd_y[0]", gy[0], 0);
            check("clamp rd_y[3]", gy[3], 0);
            check("clamp rd_y[4]", gy[4], 1);
            check("clamp strip0 rd_x", gx[0], 0);
            check("clamp strip1 rd_x", gx[9], 0);
            check("clamp strip2 rd_x", gx[18], 1);
            check("clamp strip3 rd_x", gx[27], 3);
         end
         if (i == 4) begin
            check("edge rd_x held", gx[5], 45);
            check("edge rd_y row1", gy[1], 47);
            check("edge rd_y row0", gy[0], 46);
         end
      end

      // Start while busy is ignored; start in first idle cycle is taken.
      @(negedge clk);
      apply(0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      for (int c = 1; c <= 13; c++) begin
         if (c > 1) @(negedge clk);
         if (rd_en) cnt++;
         if (c == 4) begin
            bx = 6'd1; by = 6'd1; mx = 10'd3; my = 10'd3; wc = 2'd2; hc = 2'd2;
            start = 1'b1;
         end else if (c == 13) begin
            check("b2b busy low at 13", busy, 0);
            check("b2b frac kept", frac0, 21);
            apply(1);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      check("b2b read count", cnt, 10);
      @(negedge clk);
      start = 1'b0;
      check("b2b new rd_en", rd_en, 1);
      check("b2b new rd_x", rdx, 3);
      check("b2b new rd_y", rdy, 4);
      check("b2b new frac", frac1, 0);
      for (int c = 0; c < 20 && busy; c++) @(negedge clk);
      check("b2b second block done", busy, 0);

      // Reset in cycle 5 of an 8x8 block.
      @(negedge clk);
      apply(2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre-reset busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst ctrl zero", {busy, rd_en, rvalid, rd_end}, 0);
      check("midrst addr/frac zero", {rdx, rdy, frac0, frac1}, 0);
      check("midrst refuv zero", {u0, u1, u2, v0, v1, v2}, 0);
      cnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (rd_end || rvalid) cnt++;
      end
      check("midrst no end/valid", cnt, 0);
      rst_n = 1'b1;
      run_block(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
